// File: rtl/popcount_accum.sv
// Frame hamming-weight accumulator: sums per-beat popcounts (ones or zeros) over a frame
// and holds the total until consumed. Define POPCOUNT_ACCUM_SATURATE_EN to saturate instead of wrap.
module popcount_accum #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  mode_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [CNT_WIDTH-1:0]  out_count_o,
  output logic                  out_overflow_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam int WW = $clog2(DATA_WIDTH) + 1;

  generate
    if (DATA_WIDTH < 1) begin : g_bad_data_width
      $error("popcount_accum: DATA_WIDTH must be >= 1");
    end
    if (CNT_WIDTH < WW) begin : g_bad_cnt_width
      $error("popcount_accum: CNT_WIDTH must be >= $clog2(DATA_WIDTH)+1");
    end
  endgenerate

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   out_ovf_q, out_ovf_d;

  logic [DATA_WIDTH-1:0]  beat_bits;
  logic [WW-1:0]          weight;
  logic                   accept;
  logic                   frame_clr;
  logic [CNT_WIDTH-1:0]   acc_base;
  logic                   ovf_base;
  logic [CNT_WIDTH:0]     sum;
  logic                   ovf_new;
  logic [CNT_WIDTH-1:0]   total;

  // Counting zeros is counting ones of the inverted beat.
  assign beat_bits = mode_i ? ~in_data_i : in_data_i;

  always_comb begin
    weight = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      weight = weight + WW'(beat_bits[i]);
    end
  end

  assign accept    = in_valid_i && in_ready_o;
  assign frame_clr = clear_i && (state_q == ACCUM);

  // A clear in the same cycle as a beat makes that beat the first of a fresh frame.
  assign acc_base = frame_clr ? '0 : acc_q;
  assign ovf_base = frame_clr ? 1'b0 : ovf_q;
  assign sum      = {1'b0, acc_base} + {{(CNT_WIDTH + 1 - WW){1'b0}}, weight};
  assign ovf_new  = ovf_base | sum[CNT_WIDTH];

`ifdef POPCOUNT_ACCUM_SATURATE_EN
  assign total = ovf_new ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
`else
  assign total = sum[CNT_WIDTH-1:0];
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && in_last_i) state_d = HOLD;
      HOLD:    if (out_ready_i)         state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready_o  = (state_q == ACCUM);
    out_valid_o = (state_q == HOLD);
  end

  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    out_ovf_d = out_ovf_q;
    if (state_q == ACCUM) begin
      if (frame_clr) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
      if (accept) begin
        if (in_last_i) begin
          count_d   = total;
          out_ovf_d = ovf_new;
          acc_d     = '0;
          ovf_d     = 1'b0;
        end else begin
          acc_d = total;
          ovf_d = ovf_new;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_count_o    = count_q;
  assign out_overflow_o = out_ovf_q;

endmodule

// File: tb/tb_popcount_accum.sv
// Directed self-checking bench for popcount_accum at DATA_WIDTH=8, CNT_WIDTH=4.
module tb_popcount_accum;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       mode;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_count;
  logic       out_ovf;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  popcount_accum #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .mode_i        (mode),
    .in_data_i     (in_data),
    .in_last_i     (in_last),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .out_count_o   (out_count),
    .out_overflow_o(out_ovf),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one beat, waits (bounded) for acceptance, returns 1 time unit after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic m, input logic c);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    mode     = m;
    clear    = c;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout data=%h in_ready=%b required 1", d, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    clear    = 1'b0;
    $display("beat data=%h last=%b mode=%b clear=%b", d, l, m, c);
  endtask

  task automatic pop_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pop_return valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic check_result(input string name, input logic [3:0] exp_cnt, input logic exp_ovf);
    checks++;
    if (out_valid !== 1'b1 || out_count !== exp_cnt || out_ovf !== exp_ovf || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s valid=%b count=%0d ovf=%b ready=%b required valid=1 count=%0d ovf=%b ready=0",
               name, out_valid, out_count, out_ovf, in_ready, exp_cnt, exp_ovf);
    end else begin
      $display("result %s count=%0d ovf=%b", name, out_count, out_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 4'd0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ready=%b valid=%b count=%0d ovf=%b required 1 0 0 0",
               in_ready, out_valid, out_count, out_ovf);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset ready=%b valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ones_frame();
    send_beat(8'hFF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
    send_beat(8'h0F, 1'b1, 1'b0, 1'b0);
    check_result("ones_ff_0f", 4'd12, 1'b0);
    pop_result();
  endtask

  task automatic test_zeros_single();
    send_beat(8'h01, 1'b1, 1'b1, 1'b0);
    check_result("zeros_single_01", 4'd7, 1'b0);
    pop_result();
  endtask

  task automatic test_mode_mix();
    // 0xF0 ones -> 4, then 0x00 zeros -> 8
    send_beat(8'hF0, 1'b0, 1'b0, 1'b0);
    send_beat(8'h00, 1'b1, 1'b1, 1'b0);
    check_result("mode_mix", 4'd12, 1'b0);
    pop_result();
  endtask

  task automatic test_overflow();
`ifdef POPCOUNT_ACCUM_SATURATE_EN
    logic [3:0] exp_cnt = 4'd15;
`else
    logic [3:0] exp_cnt = 4'd0;
`endif
    send_beat(8'hFF, 1'b0, 1'b0, 1'b0);
    send_beat(8'hFF, 1'b1, 1'b0, 1'b0);
    check_result("overflow_ff_ff", exp_cnt, 1'b1);
    pop_result();
    // Overflow flag must not leak into the next frame.
    send_beat(8'h03, 1'b1, 1'b0, 1'b0);
    check_result("after_overflow", 4'd2, 1'b0);
    pop_result();
  endtask

  task automatic test_hold_stall();
    send_beat(8'h0F, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    clear    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_count !== 4'd4 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stall cycle=%0d valid=%b count=%0d ovf=%b ready=%b required 1 4 0 0",
                 i, out_valid, out_count, out_ovf, in_ready);
      end
    end
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("hold_delivered", 4'd4, 1'b0);
    pop_result();
  endtask

  task automatic test_reset_midframe();
    send_beat(8'hFF, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #3;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 4'd0) begin
      errors++;
      $display("FAIL midframe_reset ready=%b valid=%b count=%0d required 1 0 0",
               in_ready, out_valid, out_count);
    end
    send_beat(8'h03, 1'b1, 1'b0, 1'b0);
    check_result("reset_midframe", 4'd2, 1'b0);
    pop_result();
  endtask

  task automatic test_clear();
    send_beat(8'hF0, 1'b0, 1'b0, 1'b0);
    send_beat(8'h07, 1'b1, 1'b0, 1'b1);
    check_result("clear_same_cycle", 4'd3, 1'b0);
    pop_result();
    // Clear on an idle cycle also discards the partial frame.
    send_beat(8'hFF, 1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    send_beat(8'h01, 1'b1, 1'b0, 1'b0);
    check_result("clear_idle", 4'd1, 1'b0);
    pop_result();
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    mode      = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_ones_frame();
    test_zeros_single();
    test_mode_mix();
    test_overflow();
    test_hold_stall();
    test_reset_midframe();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount_accum.md
POPCOUNT_ACCUM -- requirements
Module: popcount_accum

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each input beat; legal range >= 1.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the frame accumulator and result; SHALL be >= $clog2(DATA_WIDTH)+1, else elaboration $error.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port clear_i, input, 1: synchronous abort; discards the partial frame.
REQ-006 SHALL have port mode_i, input, 1: 0 counts ones, 1 counts zeros; sampled per accepted beat.
REQ-007 SHALL have port in_data_i, input, DATA_WIDTH: beat payload.
REQ-008 SHALL have port in_last_i, input, 1: marks the final beat of a frame.
REQ-009 SHALL have port in_valid_i, input, 1: beat valid.
REQ-010 SHALL have port in_ready_o, output, 1: beat accepted when in_valid_i && in_ready_o.
REQ-011 SHALL have port out_count_o, output, CNT_WIDTH: frame hamming-weight total.
REQ-012 SHALL have port out_overflow_o, output, 1: frame total exceeded 2^CNT_WIDTH-1.
REQ-013 SHALL have port out_valid_o, output, 1: result valid.
REQ-014 SHALL have port out_ready_i, input, 1: result consumed when out_valid_o && out_ready_i.

Function
REQ-015 SHALL implement two states: ACCUM (in_ready_o=1, out_valid_o=0) and HOLD (in_ready_o=0, out_valid_o=1).
REQ-016 Per-beat weight SHALL be the number of ones of in_data_i (mode_i=0) or of ~in_data_i (mode_i=1), width $clog2(DATA_WIDTH)+1, computed combinationally.
REQ-017 In ACCUM, an accepted non-last beat SHALL add its weight to the accumulator, visible the next cycle.
REQ-018 In ACCUM, an accepted last beat SHALL register accumulator+weight into out_count_o, clear the accumulator and enter HOLD; out_valid_o SHALL rise the cycle after acceptance (latency 1).
REQ-019 A single-beat frame (in_last_i=1 on the first beat) SHALL yield that beat's weight alone.
REQ-020 Overflow SHALL be a per-frame flag, set when any addition carries beyond CNT_WIDTH bits, reported on out_overflow_o with the result and cleared at frame start.
REQ-021 In HOLD, out_count_o and out_overflow_o SHALL stay stable until the output handshake; the handshake SHALL return to ACCUM next cycle (no input/output same-cycle bypass).
REQ-022 clear_i in ACCUM SHALL zero accumulator and overflow flag; a beat accepted in the same cycle SHALL be counted as the first beat of a fresh frame.
REQ-023 clear_i in HOLD SHALL be ignored; a pending result is never dropped.

Reset
REQ-024 On rst_i assertion, the block SHALL immediately enter ACCUM with accumulator=0, overflow flag=0, out_count_o=0, out_overflow_o=0, out_valid_o=0.
REQ-025 Reset mid-frame or in HOLD SHALL discard all partial or pending results; in_ready_o SHALL be 1 on the first cycle after deassertion.

Configuration
REQ-026 With POPCOUNT_ACCUM_SATURATE_EN defined, on overflow the accumulator and result SHALL saturate at 2^CNT_WIDTH-1 and remain there for the rest of the frame.
REQ-027 Without POPCOUNT_ACCUM_SATURATE_EN, the accumulator SHALL wrap modulo 2^CNT_WIDTH; out_overflow_o SHALL assert in both builds.

Verification (DATA_WIDTH=8, CNT_WIDTH=4)
REQ-028 Beats 0xFF, 0x0F(last), mode_i=0 -> out_count_o=12, out_overflow_o=0, out_valid_o high one cycle after the last beat is accepted.
REQ-029 Single beat 0x01(last), mode_i=1 -> out_count_o=7.
REQ-030 Beats 0xFF, 0xFF(last) -> out_overflow_o=1; out_count_o=0 without the macro, 15 with POPCOUNT_ACCUM_SATURATE_EN.
REQ-031 Result pending, out_ready_i low 5 cycles, in_valid_i and clear_i high -> out_count_o stable, in_ready_o=0, result delivered intact when out_ready_i rises; in_ready_o=1 next cycle.
REQ-032 Beat 0xFF accepted, then rst_i pulsed, then 0x03(last) -> out_count_o=2, out_overflow_o=0.
REQ-033 Beat 0xF0 accepted, then clear_i with beat 0x07(last) accepted in the same cycle -> out_count_o=3.
